pcileech_bar_impl_ram_param: RTL and testbench



---
 rtl/pcileech_bar_pkg.sv | 9 +
 rtl/pcileech_bar_rsp_fifo.sv | 52 +++++
 rtl/pcileech_bar_impl_ram_param.sv | 91 +++++++++
 tb/tb_pcileech_bar_impl_ram_param.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_bar_pkg.sv
// pcileech_bar_pkg: shared types for the BAR RAM backend (completion context and response entry)
package pcileech_bar_pkg;
    localparam int BAR_CTX_W = 88;
    typedef logic [BAR_CTX_W-1:0] bar_ctx_t;
    typedef struct packed {
        bar_ctx_t    ctx;
        logic [31:0] data;
    } bar_rsp_t;
endpackage

// File: rtl/pcileech_bar_rsp_fifo.sv
// pcileech_bar_rsp_fifo: synchronous response FIFO whose head sits in an output register
//   push/din : enqueue one entry
//   pop      : dequeue the head (only effective while valid)
//   dout/valid : registered head entry
//   count    : total entries held, including the head register
module pcileech_bar_rsp_fifo
    import pcileech_bar_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  bar_rsp_t               din,
    input  logic                   pop,
    output bar_rsp_t               dout,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    bar_rsp_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] n;
    logic load, from_mem, bypass, wr_mem;
    // The head register refills whenever it is empty or being popped; an
    // incoming entry skips the array when the array has nothing older.
    assign load     = !valid || pop;
    assign from_mem = load && |n;
    assign bypass   = load && !(|n) && push;
    assign wr_mem   = push && !bypass;
    assign count    = n + (AW+1)'(valid);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
            wp    <= '0;
            rp    <= '0;
            n     <= '0;
        end else begin
            if (load) begin
                valid <= from_mem || push;
                dout  <= from_mem ? mem[rp] : push ? din : dout;
            end
            if (wr_mem) wp <= wp + 1'b1;
            if (from_mem) rp <= rp + 1'b1;
            n <= n + (AW+1)'(wr_mem) - (AW+1)'(from_mem);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_mem) mem[wp] <= din;
    end
endmodule

// File: rtl/pcileech_bar_impl_ram_param.sv
// pcileech_bar_impl_ram_param: parametrised BAR RAM with write window, byte enables and flow-controlled reads
//   wr_addr/wr_be/wr_data/wr_valid : always-accepted byte-enabled write
//   rd_req_ctx/addr/valid/ready    : read request with credit-based ready
//   rd_rsp_ctx/data/valid/ready    : in-order read response, held under backpressure
//   wr_drop_cnt                    : saturating count of writes outside the window
module pcileech_bar_impl_ram_param
    import pcileech_bar_pkg::*;
#(
    parameter int          ADDR_BITS  = 12,
    parameter int          WR_LO_WORD = 0,
    parameter int          WR_HI_WORD = 2**(ADDR_BITS-2)-1,
    parameter logic [31:0] INIT_VALUE = 32'h00000000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wr_addr,
    input  logic [3:0]  wr_be,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    input  bar_ctx_t    rd_req_ctx,
    input  logic [31:0] rd_req_addr,
    input  logic        rd_req_valid,
    output logic        rd_req_ready,
    output bar_ctx_t    rd_rsp_ctx,
    output logic [31:0] rd_rsp_data,
    output logic        rd_rsp_valid,
    input  logic        rd_rsp_ready,
    output logic [15:0] wr_drop_cnt
);
    localparam int WORDS = 2**(ADDR_BITS-2);
    localparam int CW    = $clog2(FIFO_DEPTH);

    if (ADDR_BITS < 6 || ADDR_BITS > 16 || WR_LO_WORD > WR_HI_WORD ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("pcileech_bar_impl_ram_param: illegal parameter combination");
    end

    logic [31:0] ram [WORDS] = '{default: INIT_VALUE};
    logic [ADDR_BITS-3:0] wi, ri;
    logic wr_in_win, wr_ok, rd_acc;
    logic s1_v, s2_v;
    bar_ctx_t s1_ctx;
    logic [31:0] s1_data;
    bar_rsp_t s2, fifo_out;
    logic [CW:0] fifo_cnt;
    logic unused;

    assign wi        = wr_addr[ADDR_BITS-1:2];
    assign ri        = rd_req_addr[ADDR_BITS-1:2];
    assign wr_in_win = 32'(wi) >= WR_LO_WORD && 32'(wi) <= WR_HI_WORD;
    assign wr_ok     = wr_valid && wr_in_win && !rst;
    // Credits cover the FIFO plus both pipeline stages, so a push never finds it full.
    assign rd_req_ready = !rst && ((CW+2)'(fifo_cnt) + (CW+2)'(s1_v) + (CW+2)'(s2_v)) < (CW+2)'(FIFO_DEPTH);
    assign rd_acc      = rd_req_valid && rd_req_ready;
    assign rd_rsp_ctx  = fifo_out.ctx;
    assign rd_rsp_data = fifo_out.data;
    assign unused      = ^{wr_addr[31:ADDR_BITS], wr_addr[1:0], rd_req_addr[31:ADDR_BITS], rd_req_addr[1:0]};

    // Read-first: the read samples the word before a same-cycle write lands.
    always_ff @(posedge clk) begin
        if (rd_acc) s1_data <= ram[ri];
        for (int b = 0; b < 4; b++)
            if (wr_ok && wr_be[b]) ram[wi][8*b +: 8] <= wr_data[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v        <= 1'b0;
            s2_v        <= 1'b0;
            wr_drop_cnt <= '0;
        end else begin
            s1_v <= rd_acc;
            s2_v <= s1_v;
            if (wr_valid && !wr_in_win && wr_drop_cnt != 16'hFFFF) wr_drop_cnt <= wr_drop_cnt + 1'b1;
        end
        if (rd_acc) s1_ctx <= rd_req_ctx;
        s2 <= '{ctx: s1_ctx, data: s1_data};
    end

    pcileech_bar_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_v),
        .din   (s2),
        .pop   (rd_rsp_valid && rd_rsp_ready),
        .dout  (fifo_out),
        .valid (rd_rsp_valid),
        .count (fifo_cnt)
    );
endmodule

// File: tb/tb_pcileech_bar_impl_ram_param.sv
// tb_pcileech_bar_impl_ram_param: scoreboard bench for the BAR RAM backend against an array model
module tb_pcileech_bar_impl_ram_param;
    import pcileech_bar_pkg::*;
    localparam int AB = 12, LO = 1, HI = 15, FD = 4, NW = 1024;
    localparam logic [31:0] INIT = 32'h5A5AC3C3;

    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] wr_addr = '0, wr_data = '0, rd_req_addr = '0;
    logic [3:0] wr_be = '0;
    logic wr_valid = 1'b0, rd_req_valid = 1'b0, rd_rsp_ready = 1'b1;
    bar_ctx_t rd_req_ctx = '0;
    logic rd_req_ready, rd_rsp_valid;
    bar_ctx_t rd_rsp_ctx;
    logic [31:0] rd_rsp_data;
    logic [15:0] wr_drop_cnt;

    typedef struct { bar_ctx_t ctx; logic [31:0] data; } exp_t;
    exp_t exp_q [$];
    exp_t mon_e;
    logic [31:0] mdl [NW];
    int mdl_drop = 0;
    int n_vec = 0, n_err = 0;
    logic hold = 1'b0;
    bar_ctx_t p_ctx;
    logic [31:0] p_data, last_data;

    always #5 clk = ~clk;

    pcileech_bar_impl_ram_param #(
        .ADDR_BITS(AB), .WR_LO_WORD(LO), .WR_HI_WORD(HI), .INIT_VALUE(INIT), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_valid(wr_valid),
        .rd_req_ctx(rd_req_ctx), .rd_req_addr(rd_req_addr), .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready),
        .rd_rsp_ctx(rd_rsp_ctx), .rd_rsp_data(rd_rsp_data), .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_ready(rd_rsp_ready), .wr_drop_cnt(wr_drop_cnt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bar_ctx_t rnd_ctx();
        return BAR_CTX_W'({$urandom, $urandom, $urandom});
    endfunction

    // Reference model: memory as a word array, reads see the state before this cycle's write.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mdl_drop = 0;
        end else begin
            if (rd_req_valid && rd_req_ready) exp_q.push_back('{rd_req_ctx, mdl[rd_req_addr[AB-1:2]]});
            if (wr_valid) begin
                if (rd_req_addr[AB-1:2] >= 0 && wr_addr[AB-1:2] >= LO && wr_addr[AB-1:2] <= HI) begin
                    for (int b = 0; b < 4; b++)
                        if (wr_be[b]) mdl[wr_addr[AB-1:2]][8*b +: 8] = wr_data[8*b +: 8];
                end else if (mdl_drop < 65535) mdl_drop++;
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks output hold under backpressure.
    always @(negedge clk) begin
        if (rst) hold = 1'b0;
        else begin
            if (hold) begin
                chk("hold_valid", rd_rsp_valid, 1'b1);
                chk("hold_payload", {rd_rsp_ctx, rd_rsp_data}, {p_ctx, p_data});
            end
            if (rd_rsp_valid && rd_rsp_ready) begin
                last_data = rd_rsp_data;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got data %h, expected no response", rd_rsp_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp", {rd_rsp_ctx, rd_rsp_data}, {mon_e.ctx, mon_e.data});
                end
            end
            hold   = rd_rsp_valid && !rd_rsp_ready;
            p_ctx  = rd_rsp_ctx;
            p_data = rd_rsp_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        logic acc;
        int i;
        rd_req_valid = 1'b1; rd_req_addr = a; rd_req_ctx = rnd_ctx();
        acc = 1'b0;
        for (i = 0; i < 200 && !acc; i++) begin
            acc = rd_req_ready;
            step();
        end
        rd_req_valid = 1'b0;
        chk("rd_accept", acc, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !rd_rsp_valid) break;
            step();
        end
        chk("drain_outstanding", 128'(exp_q.size()), 0);
    endtask

    initial begin
        int acc;
        for (int i = 0; i < NW; i++) mdl[i] = INIT;
        repeat (3) step();
        chk("ready_in_rst", rd_req_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", rd_req_ready, 1'b1);
        chk("valid_after_rst", rd_rsp_valid, 1'b0);
        chk("data_after_rst", rd_rsp_data, 0);
        chk("ctx_after_rst", rd_rsp_ctx, 0);
        chk("drop_after_rst", wr_drop_cnt, 0);

        // full-word write then read, with latency check
        wr(32'h010, 4'hF, 32'hA5A5A5A5);
        rd(32'h010);
        chk("lat_t1", rd_rsp_valid, 1'b0);
        step();
        chk("lat_t2", rd_rsp_valid, 1'b0);
        step();
        chk("lat_t3", rd_rsp_valid, 1'b1);
        drain();
        chk("full_write", last_data, 32'hA5A5A5A5);

        // byte-enable merge, read through an aliased address
        wr(32'h010, 4'hF, 32'hFFFFFFFF);
        wr(32'h010, 4'b0101, 32'h11223344);
        rd(32'h1010);
        drain();
        chk("be_merge_alias", last_data, 32'hFF22FF44);

        // write window boundaries and drop counter
        wr(32'h040, 4'hF, 32'h12345678);
        chk("drop_hi", wr_drop_cnt, 1);
        rd(32'h040);
        drain();
        chk("rejected_unchanged", last_data, INIT);
        wr(32'h000, 4'hF, 32'h87654321);
        chk("drop_lo", wr_drop_cnt, 2);
        wr(32'h014, 4'h0, 32'hDEADDEAD);
        chk("be0_not_counted", wr_drop_cnt, 2);
        wr(32'h03C, 4'hF, 32'hCAFEF00D);
        wr(32'h004, 4'hF, 32'h0000BEEF);
        chk("edges_accepted", wr_drop_cnt, 2);
        rd(32'h03C);
        drain();
        chk("word_hi", last_data, 32'hCAFEF00D);
        rd(32'h004);
        drain();
        chk("word_lo", last_data, 32'h0000BEEF);

        // same-cycle write/read ordering
        wr(32'h008, 4'hF, 32'h0);
        wr_valid = 1'b1; wr_addr = 32'h008; wr_be = 4'hF; wr_data = 32'h1;
        rd(32'h008);
        wr_valid = 1'b0;
        drain();
        chk("same_cycle_old", last_data, 0);
        rd(32'h008);
        drain();
        chk("next_cycle_new", last_data, 1);

        // backpressure: credits limit acceptance to FIFO depth
        rd_rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            rd_req_valid = 1'b1; rd_req_addr = 32'(i) << 2; rd_req_ctx = rnd_ctx();
            if (rd_req_ready) acc++;
            step();
        end
        rd_req_valid = 1'b0;
        chk("bp_accepted", 128'(acc), FD);
        chk("bp_ready_low", rd_req_ready, 1'b0);
        repeat (5) step();
        chk("bp_still_low", rd_req_ready, 1'b0);
        chk("bp_valid_held", rd_rsp_valid, 1'b1);
        rd_rsp_ready = 1'b1;
        drain();
        chk("bp_ready_back", rd_req_ready, 1'b1);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            wr_valid = 1'($urandom);
            wr_addr = ($urandom & 32'hFFFFF003) | (32'($urandom_range(0, 20)) << 2);
            wr_be = 4'($urandom);
            wr_data = $urandom;
            rd_req_valid = 1'($urandom);
            rd_req_addr = ($urandom & 32'hFFFFF003) | (32'($urandom_range(0, 20)) << 2);
            rd_req_ctx = rnd_ctx();
            rd_rsp_ready = $urandom_range(0, 3) != 0;
            step();
        end
        wr_valid = 1'b0; rd_req_valid = 1'b0; rd_rsp_ready = 1'b1;
        drain();
        chk("rand_drop", wr_drop_cnt, 128'(mdl_drop));

        // reset with reads in flight; writes during reset ignored
        wr(32'h014, 4'hF, 32'h0BADCAFE);
        rd_req_valid = 1'b1; rd_req_addr = 32'h010; rd_req_ctx = rnd_ctx();
        step();
        rd_req_addr = 32'h014; rd_req_ctx = rnd_ctx();
        step();
        rd_req_valid = 1'b0;
        rst = 1'b1;
        wr_valid = 1'b1; wr_addr = 32'h014; wr_be = 4'hF; wr_data = 32'hFFFF0000;
        step();
        step();
        wr_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", rd_rsp_valid, 1'b0);
        chk("mid_rst_data", rd_rsp_data, 0);
        chk("mid_rst_drop", wr_drop_cnt, 0);
        repeat (6) step();
        chk("no_stale_rsp", rd_rsp_valid, 1'b0);
        rd(32'h014);
        drain();
        chk("mem_survives_rst", last_data, 32'h0BADCAFE);

        // drop counter saturation
        wr_valid = 1'b1; wr_addr = 32'h080; wr_be = 4'hF; wr_data = 32'h0;
        repeat (65534) step();
        chk("drop_fffe", wr_drop_cnt, 16'hFFFE);
        repeat (70000 - 65534) step();
        wr_valid = 1'b0;
        chk("drop_saturated", wr_drop_cnt, 16'hFFFF);
        chk("drop_model", wr_drop_cnt, 128'(mdl_drop));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
